// File: rtl/moving_average_window_ctrl.sv
// moving_average_window_ctrl
//    Sequencer for the moving-average filter bank. Owns the applied window
//    select, clears the filters on reset or select change, then counts
//    filtered strobes until the selected window is full. Until the window is
//    full the output strobe is gated so no partial average reaches the pins.
//
//    Optional feature macro: MA_DROP_COUNT_EN
//       defined   -> drop_cnt_o counts strobe_i pulses that arrive while the
//                    filters are being cleared (8-bit, saturating, reset-only clear)
//       undefined -> drop_cnt_o is tied to zero and no counter is built

module moving_average_window_ctrl #(
   parameter int CNT_W   = 4,
   parameter int WARM0   = 2,
   parameter int WARM1   = 4,
   parameter int WARM2   = 8,
   parameter int WARM3   = 9,
   parameter int CLR_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       sel_req_i,
   input  logic             strobe_i,
   input  logic             strobe_flt_i,
   output logic [1:0]       sel_o,
   output logic             flt_clr_o,
   output logic             flt_strobe_o,
   output logic             strobe_o,
   output logic             settled_o,
   output logic             switch_ack_o,
   output logic [CNT_W-1:0] warm_cnt_o,
   output logic [7:0]       drop_cnt_o
);

   localparam int HOLD_W = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC + 1);

   typedef enum logic [1:0] {
      CLEAR,
      WARMUP,
      RUN
   } ctrlState_t;

   ctrlState_t       r_state;
   logic [HOLD_W-1:0] r_holdCnt;
   logic [1:0]       r_sel;
   logic             r_fltClr;
   logic             r_strobe;
   logic             r_settled;
   logic             r_switchAck;
   logic [CNT_W-1:0] r_warmCnt;

   logic [31:0]      w_warmTarget;
   logic [CNT_W-1:0] w_cntInc;
   logic [31:0]      w_cntIncExt;
   logic             w_selChange;
   logic             w_windowFull;
   logic             w_inClear;

   // Number of filtered strobes needed to fill the window of the applied select
   always_comb begin
      w_warmTarget = 32'(WARM0);
      case (r_sel)
         2'b00:   w_warmTarget = 32'(WARM0);
         2'b01:   w_warmTarget = 32'(WARM1);
         2'b10:   w_warmTarget = 32'(WARM2);
         default: w_warmTarget = 32'(WARM3);
      endcase
   end

   // Saturating next value of the warm-up counter and the "window full" test;
   // using >= lets a window size of 0 or 1 settle on the very first strobe
   always_comb begin
      w_cntInc     = (r_warmCnt == {CNT_W{1'b1}}) ? r_warmCnt : r_warmCnt + 1'b1;
      w_cntIncExt  = 32'(w_cntInc);
      w_windowFull = (w_cntIncExt >= w_warmTarget);
   end

   assign w_selChange = (sel_req_i != r_sel);
   assign w_inClear   = (r_state == CLEAR);

   // Raw strobes are kept away from the filters while they are being cleared
   assign flt_strobe_o = strobe_i & ~w_inClear;

   // Main sequencer: clear phase, warm-up counting, then free-running forwarding.
   // A select change always wins over a simultaneous filtered strobe.
   // In CLEAR the first cycle only raises the clear; the hold counter then
   // measures how long the clear has been high, so a select change inside
   // CLEAR keeps the clear asserted and simply restarts the hold period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= CLEAR;
         r_holdCnt   <= '0;
         r_sel       <= 2'b00;
         r_fltClr    <= 1'b0;
         r_strobe    <= 1'b0;
         r_settled   <= 1'b0;
         r_switchAck <= 1'b0;
         r_warmCnt   <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_strobe    <= 1'b0;
               r_settled   <= 1'b0;
               r_switchAck <= 1'b0;
               r_warmCnt   <= '0;
               if (w_selChange) begin
                  r_sel     <= sel_req_i;
                  r_holdCnt <= '0;
                  r_fltClr  <= 1'b1;
               end else if (!r_fltClr) begin
                  r_fltClr <= 1'b1;
               end else if (r_holdCnt == HOLD_W'(CLR_CYC - 1)) begin
                  r_fltClr  <= 1'b0;
                  r_holdCnt <= '0;
                  r_state   <= WARMUP;
               end else begin
                  r_holdCnt <= r_holdCnt + 1'b1;
               end
            end

            WARMUP: begin
               r_fltClr    <= 1'b0;
               r_switchAck <= 1'b0;
               if (w_selChange) begin
                  r_sel     <= sel_req_i;
                  r_state   <= CLEAR;
                  r_holdCnt <= '0;
                  r_settled <= 1'b0;
                  r_strobe  <= 1'b0;
                  r_warmCnt <= '0;
               end else if (strobe_flt_i) begin
                  r_warmCnt <= w_cntInc;
                  if (w_windowFull) begin
                     r_strobe    <= 1'b1;
                     r_settled   <= 1'b1;
                     r_switchAck <= 1'b1;
                     r_state     <= RUN;
                  end else begin
                     r_strobe <= 1'b0;
                  end
               end else begin
                  r_strobe <= 1'b0;
               end
            end

            RUN: begin
               r_fltClr    <= 1'b0;
               r_switchAck <= 1'b0;
               if (w_selChange) begin
                  r_sel     <= sel_req_i;
                  r_state   <= CLEAR;
                  r_holdCnt <= '0;
                  r_settled <= 1'b0;
                  r_strobe  <= 1'b0;
                  r_warmCnt <= '0;
               end else begin
                  r_settled <= 1'b1;
                  r_strobe  <= strobe_flt_i;
                  if (strobe_flt_i) begin
                     r_warmCnt <= w_cntInc;
                  end
               end
            end

            default: begin
               r_state   <= CLEAR;
               r_holdCnt <= '0;
               r_fltClr  <= 1'b0;
               r_strobe  <= 1'b0;
               r_settled <= 1'b0;
            end
         endcase
      end
   end

`ifdef MA_DROP_COUNT_EN
   logic [7:0] r_dropCnt;

   // Count raw strobes lost while the filters are cleared; saturates, reset-only clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dropCnt <= 8'h00;
      end else if (w_inClear && strobe_i && (r_dropCnt != 8'hFF)) begin
         r_dropCnt <= r_dropCnt + 8'h01;
      end
   end

   assign drop_cnt_o = r_dropCnt;
`else
   assign drop_cnt_o = 8'h00;
`endif

   assign sel_o        = r_sel;
   assign flt_clr_o    = r_fltClr;
   assign strobe_o     = r_strobe;
   assign settled_o    = r_settled;
   assign switch_ack_o = r_switchAck;
   assign warm_cnt_o   = r_warmCnt;

endmodule

// File: tb/tb_moving_average_window_ctrl.sv
// tb_moving_average_window_ctrl
//    Directed bench for the moving-average window sequencer with hand-computed
//    expectations for the default parameter set (WARM 2/4/8/9, CLR_CYC 2).

module tb_moving_average_window_ctrl;

   logic       clk;
   logic       reset;
   logic [1:0] selReq;
   logic       strobeIn;
   logic       strobeFlt;
   logic [1:0] selOut;
   logic       fltClr;
   logic       fltStrobe;
   logic       strobeOut;
   logic       settled;
   logic       switchAck;
   logic [3:0] warmCnt;
   logic [7:0] dropCnt;

   int total;
   int bad;

   moving_average_window_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .sel_req_i    (selReq),
      .strobe_i     (strobeIn),
      .strobe_flt_i (strobeFlt),
      .sel_o        (selOut),
      .flt_clr_o    (fltClr),
      .flt_strobe_o (fltStrobe),
      .strobe_o     (strobeOut),
      .settled_o    (settled),
      .switch_ack_o (switchAck),
      .warm_cnt_o   (warmCnt),
      .drop_cnt_o   (dropCnt)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expectation and tally the result
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle pulse on the filtered strobe input
   task automatic applyStimulus();
      strobeFlt = 1'b1;
      tick();
      strobeFlt = 1'b0;
   endtask

   // Count how many of the next n cycles show the filter clear asserted
   task automatic countClear(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (fltClr) cnt++;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_sel"},     32'(selOut),    32'd0);
      checkOutput({tag, "_clr"},     32'(fltClr),    32'd0);
      checkOutput({tag, "_strobe"},  32'(strobeOut), 32'd0);
      checkOutput({tag, "_settled"}, 32'(settled),   32'd0);
      checkOutput({tag, "_ack"},     32'(switchAck), 32'd0);
      checkOutput({tag, "_warm"},    32'(warmCnt),   32'd0);
      checkOutput({tag, "_drop"},    32'(dropCnt),   32'd0);
   endtask

   int clrCnt;
   int nStrobes;
   int sawStrobe;
   logic [31:0] expDrop3;
   logic [31:0] expDropSat;

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      selReq    = 2'b00;
      strobeIn  = 1'b0;
      strobeFlt = 1'b0;
`ifdef MA_DROP_COUNT_EN
      expDrop3   = 32'd3;
      expDropSat = 32'd255;
`else
      expDrop3   = 32'd0;
      expDropSat = 32'd0;
`endif

      // Test 1: reset, 2-cycle clear, 2-tap warm-up
      tick();
      tick();
      checkResetValues("rst");
      reset = 1'b0;
      countClear(10, clrCnt);
      checkOutput("t1_clr_cycles", 32'(clrCnt), 32'd2);
      applyStimulus();
      checkOutput("t1_first_gated", 32'(strobeOut), 32'd0);
      checkOutput("t1_warm1", 32'(warmCnt), 32'd1);
      checkOutput("t1_not_settled", 32'(settled), 32'd0);
      applyStimulus();
      checkOutput("t1_fwd", 32'(strobeOut), 32'd1);
      checkOutput("t1_settled", 32'(settled), 32'd1);
      checkOutput("t1_ack", 32'(switchAck), 32'd1);
      checkOutput("t1_warm2", 32'(warmCnt), 32'd2);
      tick();
      checkOutput("t1_ack_pulse", 32'(switchAck), 32'd0);
      checkOutput("t1_strobe_low", 32'(strobeOut), 32'd0);
      applyStimulus();
      checkOutput("t1_run_fwd", 32'(strobeOut), 32'd1);
      checkOutput("t1_run_warm", 32'(warmCnt), 32'd3);

      // Test 2: switch 00 -> 10, 8-tap warm-up
      selReq = 2'b10;
      tick();
      checkOutput("t2_sel", 32'(selOut), 32'd2);
      checkOutput("t2_unsettled", 32'(settled), 32'd0);
      checkOutput("t2_warm_clr", 32'(warmCnt), 32'd0);
      countClear(10, clrCnt);
      checkOutput("t2_clr_cycles", 32'(clrCnt), 32'd2);
      sawStrobe = 0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus();
         if (strobeOut) sawStrobe++;
         tick();
      end
      checkOutput("t2_gated7", 32'(sawStrobe), 32'd0);
      checkOutput("t2_warm7", 32'(warmCnt), 32'd7);
      applyStimulus();
      checkOutput("t2_fwd8", 32'(strobeOut), 32'd1);
      checkOutput("t2_settled", 32'(settled), 32'd1);
      checkOutput("t2_ack", 32'(switchAck), 32'd1);

      // Test 3: sel 11 needs exactly 9 filtered strobes
      selReq = 2'b11;
      tick();
      countClear(10, clrCnt);
      checkOutput("t3_clr_cycles", 32'(clrCnt), 32'd2);
      nStrobes = 0;
      sawStrobe = 0;
      for (int i = 0; i < 20 && sawStrobe == 0; i++) begin
         applyStimulus();
         nStrobes++;
         if (strobeOut) sawStrobe = 1;
         else tick();
      end
      checkOutput("t3_seen", 32'(sawStrobe), 32'd1);
      checkOutput("t3_count", 32'(nStrobes), 32'd9);
      checkOutput("t3_warm", 32'(warmCnt), 32'd9);

      // Test 4: change collides with a filtered strobe, then changes inside CLEAR
      selReq = 2'b01;
      applyStimulus();
      checkOutput("t4_no_fwd", 32'(strobeOut), 32'd0);
      checkOutput("t4_warm0", 32'(warmCnt), 32'd0);
      checkOutput("t4_sel", 32'(selOut), 32'd1);
      checkOutput("t4_unsettled", 32'(settled), 32'd0);
      tick();
      checkOutput("t4_clr_on", 32'(fltClr), 32'd1);
      selReq = 2'b10;
      tick();
      checkOutput("t4_sel10", 32'(selOut), 32'd2);
      selReq = 2'b01;
      tick();
      checkOutput("t4_sel01", 32'(selOut), 32'd1);
      checkOutput("t4_clr_held", 32'(fltClr), 32'd1);
      countClear(6, clrCnt);
      checkOutput("t4_clr_after_change", 32'(clrCnt + 1), 32'd2);

      // Test 5: raw strobes during CLEAR are blocked and counted
      selReq = 2'b00;
      tick();
      sawStrobe = 0;
      for (int i = 0; i < 3; i++) begin
         strobeIn = 1'b1;
         #1;
         if (fltStrobe) sawStrobe++;
         tick();
      end
      strobeIn = 1'b0;
      checkOutput("t5_blocked", 32'(sawStrobe), 32'd0);
      checkOutput("t5_drop3", 32'(dropCnt), expDrop3);
      strobeIn = 1'b1;
      #1;
      checkOutput("t5_pass_warmup", 32'(fltStrobe), 32'd1);
      strobeIn = 1'b0;
      selReq = 2'b01;
      tick();
      strobeIn = 1'b1;
      for (int i = 0; i < 300; i++) begin
         selReq = (i % 2 == 0) ? 2'b00 : 2'b01;
         tick();
      end
      strobeIn = 1'b0;
      checkOutput("t5_drop_sat", 32'(dropCnt), expDropSat);

      // Test 6: asynchronous reset in RUN, then warm-up restarts
      selReq = 2'b01;
      tick();
      countClear(6, clrCnt);
      selReq = 2'b00;
      tick();
      countClear(6, clrCnt);
      applyStimulus();
      tick();
      applyStimulus();
      checkOutput("t6_run", 32'(settled), 32'd1);
      strobeFlt = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      checkResetValues("t6_async");
      strobeFlt = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      countClear(6, clrCnt);
      checkOutput("t6_clr_cycles", 32'(clrCnt), 32'd2);
      applyStimulus();
      checkOutput("t6_warm_restart", 32'(warmCnt), 32'd1);
      checkOutput("t6_gated", 32'(strobeOut), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
